// File: rtl/myproject_div_pkg.sv
// ---------------------------------------------------------------------------
// myproject_div_pkg
// Shared constants for the sequential signed divider:
//   - operand / result widths,
//   - iteration counter width,
//   - quotient saturation limits,
//   - FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package myproject_div_pkg;

  localparam int DIVIDEND_W = 48;
  localparam int DIVISOR_W  = 18;
  localparam int QUOTIENT_W = 32;

  // Counter must be able to hold DIVIDEND_W itself (loaded at capture).
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  localparam logic [QUOTIENT_W-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [QUOTIENT_W-1:0] QMIN = 32'h8000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/myproject_div_step.sv
// ---------------------------------------------------------------------------
// myproject_div_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem      in  DW+1  partial remainder from the previous step
//   din      in  1     next dividend bit (MSB first)
//   dmag     in  DW    divisor magnitude (unsigned, may be 2^(DW-1))
//   rem_next out DW+1  partial remainder after this step
//   qbit     out 1     quotient bit produced by this step
// ---------------------------------------------------------------------------
module myproject_div_step #(
  parameter int DW = 18
) (
  input  logic [DW:0]   rem,
  input  logic          din,
  input  logic [DW-1:0] dmag,
  output logic [DW:0]   rem_next,
  output logic          qbit
);

  logic [DW:0] shifted_s;
  logic [DW:0] diff_s;

  // Shift in the next dividend bit and trial-subtract the divisor.
  // A set rem[DW] means the shifted value already exceeds any divisor,
  // so the subtraction must succeed; the wrapped difference is still exact.
  always_comb begin
    shifted_s = {rem[DW-1:0], din};
    diff_s    = shifted_s - {1'b0, dmag};
    qbit      = rem[DW] | (shifted_s >= {1'b0, dmag});
    if (qbit) begin
      rem_next = diff_s;
    end else begin
      rem_next = shifted_s;
    end
  end

endmodule

// File: rtl/myproject_sdiv_48s_18s_32_seq.sv
// ---------------------------------------------------------------------------
// myproject_sdiv_48s_18s_32_seq
// Sequential signed divider, C semantics (quotient truncates toward zero,
// remainder takes the dividend sign), one quotient bit per clock.
// Build option: define MYPROJECT_SDIV_SAT_EN to saturate out-of-range
// quotients and raise ovf; otherwise the quotient wraps and ovf stays 0.
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  high only in IDLE
//   dividend   in   signed dividend
//   divisor    in   signed divisor
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts result
//   quotient   out  signed quotient
//   remainder  out  signed remainder
//   dz         out  divide-by-zero flag
//   ovf        out  quotient overflow flag (saturating build only)
// ---------------------------------------------------------------------------
module myproject_sdiv_48s_18s_32_seq
  import myproject_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOTIENT_WIDTH = QUOTIENT_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      dz,
  output logic                      ovf
);

  localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

  state_t                    state_r;
  logic [CNT_WIDTH-1:0]      cnt_r;
  logic [DIVIDEND_WIDTH-1:0] dvd_r;      // dividend magnitude, becomes quotient magnitude
  logic [DIVISOR_WIDTH-1:0]  dmag_r;
  logic [DIVISOR_WIDTH:0]    rem_r;
  logic                      dneg_r;
  logic                      qneg_r;
  logic [QUOTIENT_WIDTH-1:0] quotient_r;
  logic [DIVISOR_WIDTH-1:0]  remainder_r;
  logic                      dz_r;
  logic                      ovf_r;

  logic [DIVIDEND_WIDTH-1:0] dvd_mag_s;
  logic [DIVISOR_WIDTH-1:0]  dsr_mag_s;
  logic [DIVISOR_WIDTH:0]    rem_next_s;
  logic                      qbit_s;
  logic [QUOTIENT_WIDTH-1:0] q_fix_s;
  logic [DIVISOR_WIDTH-1:0]  r_fix_s;
  logic                      ovf_fix_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign dz        = dz_r;
  assign ovf       = ovf_r;

  // Operand magnitudes; held unsigned so the most negative values are exact.
  always_comb begin
    if (dividend[DIVIDEND_WIDTH-1]) begin
      dvd_mag_s = -dividend;
    end else begin
      dvd_mag_s = dividend;
    end
    if (divisor[DIVISOR_WIDTH-1]) begin
      dsr_mag_s = -divisor;
    end else begin
      dsr_mag_s = divisor;
    end
  end

  myproject_div_step #(
    .DW (DIVISOR_WIDTH)
  ) u_step (
    .rem      (rem_r),
    .din      (dvd_r[DIVIDEND_WIDTH-1]),
    .dmag     (dmag_r),
    .rem_next (rem_next_s),
    .qbit     (qbit_s)
  );

  // Sign restoration of the remainder.
  always_comb begin
    if (dneg_r) begin
      r_fix_s = -rem_r[DIVISOR_WIDTH-1:0];
    end else begin
      r_fix_s = rem_r[DIVISOR_WIDTH-1:0];
    end
  end

`ifdef MYPROJECT_SDIV_SAT_EN
  logic [DIVIDEND_WIDTH:0]                qfull_s;
  logic [DIVIDEND_WIDTH-QUOTIENT_WIDTH+1:0] qhigh_s;

  // Full signed quotient; in range only if the bits above the result
  // sign bit are a pure sign extension.
  always_comb begin
    if (qneg_r) begin
      qfull_s = -{1'b0, dvd_r};
    end else begin
      qfull_s = {1'b0, dvd_r};
    end
    qhigh_s = qfull_s[DIVIDEND_WIDTH:QUOTIENT_WIDTH-1];
    if ((&qhigh_s) || !(|qhigh_s)) begin
      q_fix_s   = qfull_s[QUOTIENT_WIDTH-1:0];
      ovf_fix_s = 1'b0;
    end else if (qneg_r) begin
      q_fix_s   = QMIN;
      ovf_fix_s = 1'b1;
    end else begin
      q_fix_s   = QMAX;
      ovf_fix_s = 1'b1;
    end
  end
`else
  // Wrapping quotient: only the low bits of the signed result are kept.
  always_comb begin
    if (qneg_r) begin
      q_fix_s = -dvd_r[QUOTIENT_WIDTH-1:0];
    end else begin
      q_fix_s = dvd_r[QUOTIENT_WIDTH-1:0];
    end
    ovf_fix_s = 1'b0;
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      dvd_r       <= '0;
      dmag_r      <= '0;
      rem_r       <= '0;
      dneg_r      <= 1'b0;
      qneg_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            dneg_r <= dividend[DIVIDEND_WIDTH-1];
            qneg_r <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
            dvd_r  <= dvd_mag_s;
            dmag_r <= dsr_mag_s;
            rem_r  <= '0;
            cnt_r  <= CNT_WIDTH'(DIVIDEND_WIDTH);
            if (divisor == '0) begin
              // Divide by zero: saturate toward the dividend sign.
              if (dividend[DIVIDEND_WIDTH-1]) begin
                quotient_r <= QMIN;
              end else begin
                quotient_r <= QMAX;
              end
              remainder_r <= dividend[DIVISOR_WIDTH-1:0];
              dz_r        <= 1'b1;
              ovf_r       <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              dz_r    <= 1'b0;
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          // Quotient bits shift into the vacated low end of the dividend.
          dvd_r <= {dvd_r[DIVIDEND_WIDTH-2:0], qbit_s};
          cnt_r <= cnt_r - CNT_WIDTH'(1);
          if (cnt_r == CNT_WIDTH'(1)) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          ovf_r       <= ovf_fix_s;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_48s_18s_32_seq.sv
// Self-checking bench for the sequential signed divider.
module tb_myproject_sdiv_48s_18s_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] dividend = 48'd0;
  logic [17:0] divisor = 18'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [17:0] remainder;
  logic        dz;
  logic        ovf;

  myproject_sdiv_48s_18s_32_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [17:0] r;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] q, input logic [17:0] r, input logic d, input logic o);
    exp_t e;
    e.q = q; e.r = r; e.dz = d; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dz"}, dz, e.dz);
      chk({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge ap_clk);
      n = n + 1;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge ap_clk);
      n = n + 1;
    end
  endtask

  // Drive one operation from IDLE; result is left held in DONE.
  task automatic run_op(input longint a, input longint b, input logic [31:0] eq,
                        input logic [17:0] er, input logic edz, input logic eovf,
                        input int elat, input string tag);
    int n;
    push_exp(eq, er, edz, eovf);
    @(negedge ap_clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    dividend = a[47:0];
    divisor  = b[17:0];
    in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_latency"}, n + 1, elat);
    check_result(tag);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    chk("consume_valid_low", out_valid, 1'b0);
  endtask

  task automatic rand_op(input int k);
    logic [63:0] t;
    logic [31:0] u;
    longint a, b, q, r;
    logic [31:0] eq;
    logic eovf;
    t = {$urandom(), $urandom()};
    u = $urandom();
    a = $signed(t[47:0]);
    if (k[0]) a = a >>> 20;
    b = $signed(u[17:0]);
    if (b == 0) b = 7;
    q = a / b;
    r = a % b;
`ifdef MYPROJECT_SDIV_SAT_EN
    if (q > 64'sd2147483647) begin
      eq = 32'h7FFF_FFFF; eovf = 1'b1;
    end else if (q < -64'sd2147483648) begin
      eq = 32'h8000_0000; eovf = 1'b1;
    end else begin
      eq = q[31:0]; eovf = 1'b0;
    end
`else
    eq = q[31:0];
    eovf = 1'b0;
`endif
    run_op(a, b, eq, r[17:0], 1'b0, eovf, 50, $sformatf("rnd%0d", k));
    consume();
  endtask

  initial begin
    logic stable;
    logic rdy_seen;
    logic stale;
    int   n;
    int   t_x;
    int   t_y;

    // Reset state
    repeat (2) @(negedge ap_clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 18'd0);
    chk("rst_dz", dz, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    ap_rst_n = 1'b1;

    // 1000 / 7, then hold in DONE with in_valid pulses that must be ignored
    run_op(64'sd1000, 64'sd7, 32'd142, 18'd6, 1'b0, 1'b0, 50, "p1000_7");
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      dividend = 48'd5;
      divisor  = 18'd1;
      @(negedge ap_clk);
      if (quotient !== 32'd142 || remainder !== 18'd6 || out_valid !== 1'b1 || dz !== 1'b0)
        stable = 1'b0;
      if (in_ready === 1'b1) rdy_seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("hold_stable", stable, 1'b1);
    chk("hold_in_ready_low", rdy_seen, 1'b0);

    // Release: back-to-back -1000/7 and 5/-2^17 with out_ready held high
    push_exp(32'hFFFF_FF72, 18'h3FFFA, 1'b0, 1'b0);
    dividend  = -48'sd1000;
    divisor   = 18'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_ready();
    @(negedge ap_clk);
    push_exp(32'd0, 18'd5, 1'b0, 1'b0);
    dividend = 48'd5;
    divisor  = 18'h20000;
    wait_valid(n);
    t_x = cyc;
    chk("b2b_x_valid", out_valid, 1'b1);
    check_result("m1000_7");
    wait_ready();
    @(negedge ap_clk);
    in_valid = 1'b0;
    wait_valid(n);
    t_y = cyc;
    chk("b2b_y_valid", out_valid, 1'b1);
    check_result("p5_mmin");
    chk("b2b_spacing", t_y - t_x, 51);
    @(negedge ap_clk);
    out_ready = 1'b0;
    chk("b2b_consumed", out_valid, 1'b0);

    // Extreme magnitudes: -2^47 / -2^17
    run_op(-64'sd140737488355328, -64'sd131072, 32'h4000_0000, 18'd0, 1'b0, 1'b0, 50, "min_min");
    consume();

    // Quotient out of range: 2^40 / 1
`ifdef MYPROJECT_SDIV_SAT_EN
    run_op(64'sd1099511627776, 64'sd1, 32'h7FFF_FFFF, 18'd0, 1'b0, 1'b1, 50, "big_sat");
`else
    run_op(64'sd1099511627776, 64'sd1, 32'h0000_0000, 18'd0, 1'b0, 1'b0, 50, "big_wrap");
`endif
    consume();

    // Divide by zero
    run_op(64'sd123, 64'sd0, 32'h7FFF_FFFF, 18'd123, 1'b1, 1'b0, 1, "dz_pos");
    consume();
    run_op(-64'sd1, 64'sd0, 32'h8000_0000, 18'h3FFFF, 1'b1, 1'b0, 1, "dz_neg");
    consume();

    // Random operands against a reference model
    for (int k = 0; k < 4; k++) rand_op(k);

    // Reset in the middle of CALC
    @(negedge ap_clk);
    dividend = 48'd1000;
    divisor  = 18'd3;
    in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (20) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 18'd0);
    chk("midrst_dz", dz, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    stale = 1'b0;
    repeat (60) begin
      @(negedge ap_clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    chk("midrst_no_stale", stale, 1'b0);
    run_op(64'sd81, 64'sd9, 32'd9, 18'd0, 1'b0, 1'b0, 50, "p81_9");
    consume();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/myproject_sdiv_48s_18s_32_seq.md
# myproject_sdiv_48s_18s_32_seq

Sequential signed integer divider: 48-bit signed dividend by 18-bit signed divisor, producing a 32-bit signed quotient and an 18-bit signed remainder. It is the inverse companion of the 32s×18s→48 multiplier in the dense-layer datapath, used to de-scale accumulated products (normalisation and variance steps) back into the 32-bit activation domain. It uses restoring division at one quotient bit per clock, with a valid/ready handshake on both sides.

## Interface
Parameters:
- DIVIDEND_WIDTH, 48, signed dividend width
- DIVISOR_WIDTH, 18, signed divisor width; also the remainder width
- QUOTIENT_WIDTH, 32, signed quotient width

Ports:
- ap_clk  in  1  single clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- dividend  in  DIVIDEND_WIDTH  signed dividend
- divisor  in  DIVISOR_WIDTH  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  QUOTIENT_WIDTH  signed quotient
- remainder  out  DIVISOR_WIDTH  signed remainder
- dz  out  1  divide-by-zero flag for the current result
- ovf  out  1  quotient exceeded QUOTIENT_WIDTH signed range

## Operation
- Semantics follow C rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - |remainder| < |divisor|.
  - dividend = quotient·divisor + remainder whenever ovf=0 and dz=0.
- Operand magnitudes are held unsigned: DIVIDEND_WIDTH bits for the dividend, DIVISOR_WIDTH bits for the divisor. The extreme values −2^47 and −2^17 are therefore exact.
- FSM states IDLE, CALC, FIX, DONE:
  - IDLE: in_ready=1. On in_valid, capture the operand magnitudes, both signs and the result sign, and load counter = DIVIDEND_WIDTH.
    - divisor==0: go to DONE with dz=1, quotient = saturated value matching the dividend sign (0x7FFFFFFF if dividend ≥ 0, else 0x80000000), remainder = low DIVISOR_WIDTH bits of dividend, ovf=0.
    - Otherwise: go to CALC.
  - CALC: each cycle does one restoring step. Shift the partial remainder left, bring in the next dividend MSB, trial-subtract the divisor magnitude, and set the quotient bit if the result is non-negative. Decrement the counter; go to FIX when the counter reaches 0.
  - FIX: negate the quotient if operand signs differ, negate the remainder if the dividend is negative, apply range handling (see Configuration), register the outputs, go to DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE.
- in_ready is decoded from state only (high only in IDLE). There are no combinational paths from in_valid or out_ready to any output.
- One operation in flight at a time. A new operand set is accepted only after the previous result has been consumed.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - State goes to IDLE.
  - in_ready=1.
  - out_valid, quotient, remainder, dz and ovf are all 0.
- Latency, normal case: out_valid is high after the 50th rising edge counted from and including the accepting edge (1 capture + 48 CALC + 1 FIX).
- Latency, divide-by-zero: out_valid is high after the accepting edge itself.
- Back-to-back throughput: one result per 51 cycles when out_ready is held high (50 + 1 DONE cycle). The IDLE cycle after DONE is mandatory.
- out_ready low in DONE: hold indefinitely with outputs stable.
- Reset mid-CALC or mid-DONE: the operation is discarded, no out_valid pulse, and the block is in IDLE on the first edge after deassertion.
- in_valid while not in IDLE is ignored; operands are not sampled.

## Configuration
- MYPROJECT_SDIV_SAT_EN
  - Defined: in FIX, a signed result outside [−2^31, 2^31−1] saturates to 0x80000000 or 0x7FFFFFFF, and ovf=1 for that result.
  - Undefined: the quotient is the low QUOTIENT_WIDTH bits of the full result (wrap), ovf is tied 0, and the comparison logic is removed.
  - Remainder and dz behaviour are identical in both builds.

## Structure
- Package myproject_div_pkg holds:
  - the FSM state enum (IDLE/CALC/FIX/DONE);
  - the width constants;
  - the QMAX/QMIN saturation constants;
  - the counter width, $clog2(DIVIDEND_WIDTH+1).
- Sub-module myproject_div_step: a combinational restoring step.
  - Inputs: partial remainder (DIVISOR_WIDTH+1 bits), incoming dividend bit, divisor magnitude.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once and iterated by the FSM.

## Test plan
- 1000 / 7 → after 50 edges: quotient=142, remainder=6, dz=0, ovf=0. Then −1000 / 7 → quotient=−142, remainder=−6.
- 5 / −131072 (−2^17) → quotient=0, remainder=5; and −2^47 / −2^17 → quotient=2^30, remainder=0.
- 2^40 / 1:
  - with SAT_EN: quotient=0x7FFFFFFF, ovf=1;
  - without: quotient=0x00000000, ovf=0.
- 123 / 0 → out_valid one edge after acceptance: dz=1, quotient=0x7FFFFFFF, remainder=123. Then −1 / 0 → quotient=0x80000000.
- Hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, and in_valid pulses are ignored. Then release → back-to-back pair completes at a 51-cycle spacing.
- Assert ap_rst_n=0 at CALC cycle 20 → all outputs 0 immediately. After release, no stale out_valid, and the next operation (81 / 9 → 9 r 0) is correct.
